// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: per-cycle advance/hold/clear control for the
// five-stage RV64 pipeline (load-use bubbles, taken-branch flush, dmem wait).
//
// Parameters:
//   WAIT_MAX  max dmem wait cycles before dmem_timeout is raised
//   CNT_W     width of the performance counters
// Ports:
//   clk, reset (async, active-low)
//   id_rs1, id_rs2, id_uses_rs2    sources of the instruction in IF_ID
//   ex_rd, ex_mem_read             destination / load flag in ID_EX
//   mem_branch, mem_zero, mem_req  EX_MEM branch, ALU zero, mem access
//   dmem_ready                     data memory completed the request
//   pc_write, if_id_write          PC / IF_ID load enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush                   synchronous clear to NOP
//   pc_src                         PC takes the branch target
//   pipe_hold                      ID_EX, EX_MEM, MEM_WB hold
//   dmem_timeout                   sticky memory timeout flag
//   stall_cnt, flush_cnt           perf counters (HAZARD_PERF_CNT_EN only)
// Build option: define HAZARD_PERF_CNT_EN to add the saturating counters.

module pipeline_hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       mem_branch,
    input  logic       mem_zero,
    input  logic       mem_req,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       pc_src,
    output logic       pipe_hold,
    output logic       dmem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          timeout_q, timeout_d;

    logic load_use;
    logic taken;
    logic mem_stall;

    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) ||
                        (id_uses_rs2 && (ex_rd == id_rs2)));
    assign taken     = mem_branch && mem_zero;
    assign mem_stall = mem_req && !dmem_ready;

    assign dmem_timeout = timeout_q;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        timeout_d    = timeout_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_src       = 1'b0;
        pipe_hold    = 1'b0;

        if (state_q == ERROR) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (mem_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            // Counter already at the limit and memory still busy: give up.
            if (wait_q == WAIT_LIM) begin
                state_d   = ERROR;
                timeout_d = 1'b1;
            end else begin
                state_d = MEM_WAIT;
                wait_d  = wait_q + 1'b1;
            end
        end else begin
            state_d = RUN;
            wait_d  = '0;
            // Branch kills the wrong-path consumer, so load-use is moot.
            if (taken) begin
                pc_src       = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        // Hold every register in a cleared NOP state during reset.
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_hold    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pc_src       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != ERROR) begin
            stall_inc = mem_stall || (!taken && load_use);
            flush_inc = !mem_stall && taken;
        end
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
